// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM state codes, word geometry and NOP.
package imem_pkg;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_RUN  = 2'd1;
  localparam logic [1:0] FETCH_HALT = 2'd2;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] PC_STEP    = 32'(INST_BYTES);
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = FETCH_IDLE,
    StRun  = FETCH_RUN,
    StHalt = FETCH_HALT
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-stage bus: control inputs, instruction-memory port, IF/ID outputs and perf counters.
interface imem_fetch_ctrl_if;

  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    input  start, stall, redirect_valid, redirect_pc, imem_inst,
    output imem_pc, if_valid, if_inst, if_pc, if_pc_plus4, halted, fault,
           fetch_count, stall_count
  );

  modport slave (
    output start, stall, redirect_valid, redirect_pc, imem_inst,
    input  imem_pc, if_valid, if_inst, if_pc, if_pc_plus4, halted, fault,
           fetch_count, stall_count
  );

endinterface

// File: rtl/imem_ifid_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, hold freezes everything.
module imem_ifid_reg
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] cap_inst,
  input  logic [31:0] cap_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      pc_q       <= 32'h0;
      pc_plus4_q <= PC_STEP;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!hold) begin
      valid_q    <= 1'b1;
      inst_q     <= cap_inst;
      pc_q       <= cap_pc;
      pc_plus4_q <= cap_pc + PC_STEP;
    end
  end

  assign if_valid    = valid_q;
  assign if_inst     = inst_q;
  assign if_pc       = pc_q;
  assign if_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, sequences IDLE/RUN/HALT and feeds the IF/ID register.
// Optional perf counters are built when IMEM_FETCH_PERF_EN is defined.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 116,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  imem_fetch_ctrl_if.master   bus
);

  localparam logic [31:0] LastPc = 32'(IMEM_BYTES - INST_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         flush;
  logic         hold;

  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Outside of a capturing RUN edge the IF/ID register is flushed; hold only matters on stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    flush   = 1'b1;
    hold    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        if (bus.redirect_valid) begin
          if (!is_word_aligned(bus.redirect_pc[1:0])) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else if (bus.stall) begin
          flush = 1'b0;
          hold  = 1'b1;
        end else if (pc_q > LastPc) begin
          state_d = StHalt;
        end else begin
          flush = 1'b0;
          pc_d  = pc_q + PC_STEP;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  imem_ifid_reg u_ifid (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .flush       (flush),
    .cap_inst    (bus.imem_inst),
    .cap_pc      (pc_q),
    .if_valid    (ifid_valid),
    .if_inst     (ifid_inst),
    .if_pc       (ifid_pc),
    .if_pc_plus4 (ifid_pc_plus4)
  );

  assign bus.imem_pc     = pc_q;
  assign bus.if_valid    = ifid_valid;
  assign bus.if_inst     = ifid_inst;
  assign bus.if_pc       = ifid_pc;
  assign bus.if_pc_plus4 = ifid_pc_plus4;
  assign bus.halted      = (state_q == StHalt);
  assign bus.fault       = fault_q;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;
  logic        fetch_inc;

  assign fetch_inc = !flush && !hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      if (fetch_inc && (fetch_count_q != 32'hFFFF_FFFF)) fetch_count_q <= fetch_count_q + 32'd1;
      if (hold && (stall_count_q != 32'hFFFF_FFFF)) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
`else
  assign bus.fetch_count = 32'h0;
  assign bus.stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with literal expectations plus randomized episodes
// checked every cycle against a rule-level model of the fetch controller.
module tb_imem_fetch_ctrl;

  localparam int unsigned MemBytes = 116;
`ifdef IMEM_FETCH_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .IMEM_BYTES (MemBytes),
    .RESET_PC   (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [MemBytes];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int idx;
    if (a <= 32'(MemBytes - 4)) begin
      idx = int'(a);
      return {mem[idx], mem[idx+1], mem[idx+2], mem[idx+3]};
    end
    return 32'hDEAD_BEEF ^ a;
  endfunction

  always_comb bus.imem_inst = mem_word(bus.imem_pc);

  // Model state: 0 idle, 1 running, 2 halted.
  int          m_state;
  logic [31:0] m_pc, m_inst, m_ifpc, m_fc, m_sc;
  logic        m_valid, m_fault;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 32'h0; m_valid = 1'b0; m_inst = 32'h0; m_ifpc = 32'h0;
    m_fault = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  task automatic model_update();
    if (reset) begin
      model_reset();
    end else if (m_state == 0) begin
      if (bus.start) m_state = 1;
    end else if (m_state == 1) begin
      if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) begin
        m_fault = 1'b1; m_valid = 1'b0; m_state = 2;
      end else if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc; m_valid = 1'b0;
      end else if (bus.stall) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else if (m_pc > 32'(MemBytes - 4)) begin
        m_valid = 1'b0; m_state = 2;
      end else begin
        m_inst = mem_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_pc", bus.imem_pc, m_pc);
      check("if_valid", 32'(bus.if_valid), 32'(m_valid));
      check("if_inst", bus.if_inst, m_inst);
      check("if_pc", bus.if_pc, m_ifpc);
      check("if_pc_plus4", bus.if_pc_plus4, m_ifpc + 32'd4);
      check("halted", 32'(bus.halted), 32'(m_state == 2));
      check("fault", 32'(bus.fault), 32'(m_fault));
      check("fetch_count", bus.fetch_count, Perf ? m_fc : 32'h0);
      check("stall_count", bus.stall_count, Perf ? m_sc : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
  endtask

  // Asserted between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    chk_en = 1'b1;
    #1;
    check("rst_if_valid", 32'(bus.if_valid), 32'h0);
    check("rst_imem_pc", bus.imem_pc, 32'h0);
    check("rst_pc_plus4", bus.if_pc_plus4, 32'h4);
    check("rst_halted", 32'(bus.halted), 32'h0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(MemBytes); i++) mem[i] = 8'($urandom);
    clear_inputs();
    #2;
    do_reset();

    // Basic sequential fetch, stall, redirect-over-stall.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    check("f0_if_pc", bus.if_pc, 32'h0);
    check("f0_valid", 32'(bus.if_valid), 32'h1);
    check("f0_if_inst", bus.if_inst, {mem[0], mem[1], mem[2], mem[3]});
    step();
    check("f1_if_pc", bus.if_pc, 32'h4);
    step();
    check("f2_if_pc", bus.if_pc, 32'h8);
    check("f2_imem_pc", bus.imem_pc, 32'hC);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_imem_pc", bus.imem_pc, 32'hC);
      check("stall_if_pc", bus.if_pc, 32'h8);
      check("stall_valid", 32'(bus.if_valid), 32'h1);
    end
    check("stall_count3", bus.stall_count, Perf ? 32'd3 : 32'd0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
    step();
    check("redir_valid", 32'(bus.if_valid), 32'h0);
    check("redir_imem_pc", bus.imem_pc, 32'h10);
    clear_inputs();
    step();
    check("redir_if_pc", bus.if_pc, 32'h10);
    check("redir_valid2", 32'(bus.if_valid), 32'h1);

    // Reset mid-RUN, then IDLE ignores stall/redirect.
    do_reset();
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20;
    step();
    check("idle_imem_pc", bus.imem_pc, 32'h0);
    check("idle_valid", 32'(bus.if_valid), 32'h0);
    clear_inputs();

    // Misaligned redirect faults and halts; start is then ignored.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6;
    step();
    check("mis_fault", 32'(bus.fault), 32'h1);
    check("mis_halted", 32'(bus.halted), 32'h1);
    check("mis_valid", 32'(bus.if_valid), 32'h0);
    clear_inputs();
    bus.start = 1'b1;
    step(); step();
    check("mis_start_ign", 32'(bus.halted), 32'h1);
    check("mis_pc_frozen", bus.imem_pc, 32'h4);
    clear_inputs();

    // Full run to end of memory.
    do_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_state == 2) break;
    end
    check("end_halted", 32'(bus.halted), 32'h1);
    check("end_fault", 32'(bus.fault), 32'h0);
    check("end_last_pc", bus.if_pc, 32'h70);
    check("end_valid", 32'(bus.if_valid), 32'h0);
    check("end_fetches", bus.fetch_count, Perf ? 32'd29 : 32'd0);

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int cyc = 0; cyc < 60; cyc++) begin
        bus.start          = ($urandom % 6) == 0;
        bus.stall          = ($urandom % 4) == 0;
        bus.redirect_valid = ($urandom % 10) == 0;
        case ($urandom % 6)
          0:       bus.redirect_pc = {$urandom, 2'b01} >> 2 | 32'h1;
          1:       bus.redirect_pc = 32'hFFFF_FFFC;
          2:       bus.redirect_pc = 32'h200;
          default: bus.redirect_pc = {23'h0, 7'($urandom_range(0, 28)), 2'b00};
        endcase
        step();
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
